// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline buffers: occupancy states and the
// NOP encoding that is injected as a bubble.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Occupancy of a skid buffer in a given state; handy for debug taps.
   function automatic logic [1:0] state_occupancy(input buf_state_e st);
      logic [1:0] occ;
      occ = 2'd0;
      case (st)
         ST_ONE:  occ = 2'd1;
         ST_TWO:  occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear, used for pipeline
// performance-debug counters such as the bubble count.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline register carrying PC+4 and instruction between stages,
// with an optional two-entry skid mode, NOP-injecting flush and bubble counter.
module pipe_stage_buffer
   import pipe_pkg::*;
#(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int SKID    = 1,
   parameter int CNT_W   = 16
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               InValid,
   output logic               InReady,
   input  logic [PC_W-1:0]    PCAddResult,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               flushControl,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [PC_W-1:0]    PCAddResultOut,
   output logic [INSTR_W-1:0] InstructionOut,
   output logic [CNT_W-1:0]   BubbleCount
);

   localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

   logic               out_valid;
   logic               in_ready;
   logic [PC_W-1:0]    head_pc;
   logic [INSTR_W-1:0] head_instr;

   generate
      if (SKID != 0) begin : g_skid
         buf_state_e         state_q, state_d;
         logic               ready_q, ready_d;
         logic               accept, consume;
         logic [PC_W-1:0]    head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
         logic [INSTR_W-1:0] head_instr_q, head_instr_d, skid_instr_q, skid_instr_d;

         // Ready comes straight from a flop so OutReady never reaches InReady.
         assign accept  = InValid && ready_q;
         assign consume = (state_q != ST_EMPTY) && OutReady;

         always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
               state_q <= ST_EMPTY;
               ready_q <= 1'b1;
            end else begin
               state_q <= state_d;
               ready_q <= ready_d;
            end
         end

         always_comb begin
            state_d = state_q;
            case (state_q)
               ST_EMPTY: begin
                  if (accept) state_d = ST_ONE;
               end
               ST_ONE: begin
                  if (accept && !consume)      state_d = ST_TWO;
                  else if (!accept && consume) state_d = ST_EMPTY;
               end
               ST_TWO: begin
                  if (consume) state_d = ST_ONE;
               end
               default: state_d = ST_EMPTY;
            endcase
            if (flushControl) state_d = ST_EMPTY;
            ready_d = (state_d != ST_TWO);
         end

         always_comb begin
            out_valid  = (state_q != ST_EMPTY);
            in_ready   = ready_q;
            head_pc    = head_pc_q;
            head_instr = head_instr_q;
         end

         always_comb begin
            head_pc_d    = head_pc_q;
            head_instr_d = head_instr_q;
            skid_pc_d    = skid_pc_q;
            skid_instr_d = skid_instr_q;
            if (flushControl) begin
               head_pc_d    = '0;
               head_instr_d = NOP_W;
               skid_pc_d    = '0;
               skid_instr_d = NOP_W;
            end else begin
               case (state_q)
                  ST_EMPTY: begin
                     if (accept) begin
                        head_pc_d    = PCAddResult;
                        head_instr_d = Instruction;
                     end
                  end
                  ST_ONE: begin
                     if (accept && consume) begin
                        head_pc_d    = PCAddResult;
                        head_instr_d = Instruction;
                     end else if (accept) begin
                        skid_pc_d    = PCAddResult;
                        skid_instr_d = Instruction;
                     end
                  end
                  ST_TWO: begin
                     if (consume) begin
                        head_pc_d    = skid_pc_q;
                        head_instr_d = skid_instr_q;
                     end
                  end
                  default: ;
               endcase
            end
         end

         always_ff @(posedge Clk) begin
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
         end
      end else begin : g_single
         logic               valid_q, valid_d;
         logic               accept, consume;
         logic [PC_W-1:0]    head_pc_q, head_pc_d;
         logic [INSTR_W-1:0] head_instr_q, head_instr_d;

         assign accept  = InValid && in_ready;
         assign consume = valid_q && OutReady;

         always_comb begin
            out_valid    = valid_q;
            in_ready     = !valid_q || OutReady;
            head_pc      = head_pc_q;
            head_instr   = head_instr_q;
         end

         always_comb begin
            valid_d      = valid_q;
            head_pc_d    = head_pc_q;
            head_instr_d = head_instr_q;
            if (flushControl) begin
               valid_d      = 1'b0;
               head_pc_d    = '0;
               head_instr_d = NOP_W;
            end else if (accept) begin
               valid_d      = 1'b1;
               head_pc_d    = PCAddResult;
               head_instr_d = Instruction;
            end else if (consume) begin
               valid_d      = 1'b0;
            end
         end

         always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
               valid_q <= 1'b0;
            end else begin
               valid_q <= valid_d;
            end
         end

         always_ff @(posedge Clk) begin
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
         end
      end
   endgenerate

   // Payloads are masked so an empty buffer always presents a NOP.
   assign OutValid       = out_valid;
   assign InReady        = in_ready;
   assign PCAddResultOut = out_valid ? head_pc : '0;
   assign InstructionOut = out_valid ? head_instr : NOP_W;

   sat_counter #(
      .W(CNT_W)
   ) u_bubble_cnt (
      .clk  (Clk),
      .rst_n(Reset),
      .inc  (!out_valid),
      .count(BubbleCount)
   );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: u0 skid mode, u1 single-entry mode, u2 skid mode
// with a 3-bit bubble counter; a FIFO-style model tracks all three.
module tb_pipe_stage_buffer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        in_valid[3];
   logic        out_ready[3];
   logic        flush[3];
   logic [31:0] in_pc[3];
   logic [31:0] in_instr[3];

   logic        in_ready_o[3];
   logic        out_valid_o[3];
   logic [31:0] pc_o[3];
   logic [31:0] instr_o[3];
   logic [15:0] bc0, bc1;
   logic [2:0]  bc2;
   logic [31:0] bc_o[3];

   int n_pass  = 0;
   int n_total = 0;
   logic chk_en = 1'b0;

   always #5 Clk = ~Clk;

   pipe_stage_buffer #(.PC_W(32), .INSTR_W(32), .SKID(1), .CNT_W(16)) u0 (
      .Clk(Clk), .Reset(Reset), .InValid(in_valid[0]), .InReady(in_ready_o[0]),
      .PCAddResult(in_pc[0]), .Instruction(in_instr[0]), .flushControl(flush[0]),
      .OutValid(out_valid_o[0]), .OutReady(out_ready[0]), .PCAddResultOut(pc_o[0]),
      .InstructionOut(instr_o[0]), .BubbleCount(bc0));

   pipe_stage_buffer #(.PC_W(32), .INSTR_W(32), .SKID(0), .CNT_W(16)) u1 (
      .Clk(Clk), .Reset(Reset), .InValid(in_valid[1]), .InReady(in_ready_o[1]),
      .PCAddResult(in_pc[1]), .Instruction(in_instr[1]), .flushControl(flush[1]),
      .OutValid(out_valid_o[1]), .OutReady(out_ready[1]), .PCAddResultOut(pc_o[1]),
      .InstructionOut(instr_o[1]), .BubbleCount(bc1));

   pipe_stage_buffer #(.PC_W(32), .INSTR_W(32), .SKID(1), .CNT_W(3)) u2 (
      .Clk(Clk), .Reset(Reset), .InValid(in_valid[2]), .InReady(in_ready_o[2]),
      .PCAddResult(in_pc[2]), .Instruction(in_instr[2]), .flushControl(flush[2]),
      .OutValid(out_valid_o[2]), .OutReady(out_ready[2]), .PCAddResultOut(pc_o[2]),
      .InstructionOut(instr_o[2]), .BubbleCount(bc2));

   assign bc_o[0] = 32'(bc0);
   assign bc_o[1] = 32'(bc1);
   assign bc_o[2] = 32'(bc2);

   // Model: each buffer is a small FIFO (capacity 2 in skid mode, 1 otherwise).
   int          m_cnt[3];
   int          m_bub[3];
   logic [31:0] m_pc[3][2];
   logic [31:0] m_in[3][2];

   function automatic int bub_max(input int k);
      return (k == 2) ? 7 : 65535;
   endfunction

   function automatic logic m_ready(input int k);
      if (k != 1) return (m_cnt[k] < 2);
      return (m_cnt[k] == 0) || out_ready[k];
   endfunction

   always @(posedge Clk or negedge Reset) begin
      int          c;
      logic [31:0] p0, p1, i0, i1;
      logic        acc, cons;
      if (!Reset) begin
         for (int k = 0; k < 3; k++) begin
            m_cnt[k] <= 0;
            m_bub[k] <= 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            c  = m_cnt[k];
            p0 = m_pc[k][0]; p1 = m_pc[k][1];
            i0 = m_in[k][0]; i1 = m_in[k][1];
            acc = in_valid[k] && m_ready(k);
            if (c == 0 && m_bub[k] < bub_max(k)) m_bub[k] <= m_bub[k] + 1;
            if (flush[k]) begin
               c = 0;
            end else begin
               cons = (c > 0) && out_ready[k];
               if (cons) begin
                  p0 = p1; i0 = i1; c = c - 1;
               end
               if (acc) begin
                  if (c == 0) begin p0 = in_pc[k]; i0 = in_instr[k]; end
                  else        begin p1 = in_pc[k]; i1 = in_instr[k]; end
                  c = c + 1;
               end
            end
            m_cnt[k]   <= c;
            m_pc[k][0] <= p0; m_pc[k][1] <= p1;
            m_in[k][0] <= i0; m_in[k][1] <= i1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d_out_valid", k), 32'(out_valid_o[k]), 32'(m_cnt[k] > 0));
            check($sformatf("u%0d_pc_out", k), pc_o[k], (m_cnt[k] > 0) ? m_pc[k][0] : 32'h0);
            check($sformatf("u%0d_instr_out", k), instr_o[k], (m_cnt[k] > 0) ? m_in[k][0] : 32'h0);
            check($sformatf("u%0d_in_ready", k), 32'(in_ready_o[k]), 32'(m_ready(k)));
            check($sformatf("u%0d_bubbles", k), bc_o[k], 32'(m_bub[k]));
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input int k, input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic ordy, input logic fl);
      in_valid[k]  = v;
      in_pc[k]     = pc;
      in_instr[k]  = ins;
      out_ready[k] = ordy;
      flush[k]     = fl;
   endtask

   initial begin
      int  idx;
      logic acc;
      Reset = 1'b0;
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge Clk);
      #3;
      check("rst_out_valid", 32'(out_valid_o[0]), 32'h0);
      check("rst_pc_out", pc_o[0], 32'h0);
      check("rst_in_ready", 32'(in_ready_o[0]), 32'h1);
      check("rst_bubbles", bc_o[0], 32'h0);
      Reset  = 1'b1;
      chk_en = 1'b1;

      // Idle after reset: five bubble cycles.
      repeat (5) tick();
      check("idle_bubbles", bc_o[0], 32'd5);
      check("idle_instr_out", instr_o[0], 32'h0);

      // Streaming with OutReady high: one-cycle latency, no bubbles once flowing.
      drive(0, 1'b1, 32'h0040_0004, 32'h2008_0005, 1'b1, 1'b0);
      tick();
      check("stream1_pc", pc_o[0], 32'h0040_0004);
      check("stream1_instr", instr_o[0], 32'h2008_0005);
      check("stream1_bubbles", bc_o[0], 32'd6);
      drive(0, 1'b1, 32'h0040_0008, 32'h2009_0007, 1'b1, 1'b0);
      tick();
      check("stream2_pc", pc_o[0], 32'h0040_0008);
      check("stream2_instr", instr_o[0], 32'h2009_0007);
      check("stream2_bubbles", bc_o[0], 32'd6);
      drive(0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check("stream_drained", 32'(out_valid_o[0]), 32'h0);

      // Back-pressure: A and B absorbed, C held off until the head drains.
      drive(0, 1'b1, 32'h0000_0100, 32'h0000_00A1, 1'b0, 1'b0);
      tick();
      drive(0, 1'b1, 32'h0000_0104, 32'h0000_00B2, 1'b0, 1'b0);
      tick();
      check("bp_two_ready", 32'(in_ready_o[0]), 32'h0);
      drive(0, 1'b1, 32'h0000_0108, 32'h0000_00C3, 1'b0, 1'b0);
      tick();
      check("bp_hold_head", instr_o[0], 32'h0000_00A1);
      check("bp_hold_ready", 32'(in_ready_o[0]), 32'h0);
      out_ready[0] = 1'b1;
      tick();
      check("bp_out_b", instr_o[0], 32'h0000_00B2);
      tick();
      check("bp_out_c", instr_o[0], 32'h0000_00C3);
      check("bp_out_c_pc", pc_o[0], 32'h0000_0108);
      drive(0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();

      // Flush in TWO with a new pair presented: everything dropped.
      drive(0, 1'b1, 32'h0000_0200, 32'h0000_00D4, 1'b0, 1'b0);
      tick();
      drive(0, 1'b1, 32'h0000_0204, 32'h0000_00E5, 1'b0, 1'b0);
      tick();
      drive(0, 1'b1, 32'h0000_0208, 32'h0000_00F6, 1'b0, 1'b1);
      tick();
      check("flush_out_valid", 32'(out_valid_o[0]), 32'h0);
      check("flush_instr", instr_o[0], 32'h0);
      check("flush_ready", 32'(in_ready_o[0]), 32'h1);
      drive(0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      check("flush_dropped", 32'(out_valid_o[0]), 32'h0);

      // Single-entry mode with OutReady toggling every cycle.
      idx = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1, 1'b1, 32'h0000_1000 + 32'(idx * 4), 32'hC000_0000 + 32'(idx), i[0], 1'b0);
         #1;
         if (i == 0) check("s0_ready_empty", 32'(in_ready_o[1]), 32'h1);
         if (i == 1) check("s0_ready_comb", 32'(in_ready_o[1]), 32'h1);
         acc = in_ready_o[1];
         tick();
         if (acc) idx++;
         if (i == 0) begin
            check("s0_first_pc", pc_o[1], 32'h0000_1000);
            check("s0_ready_full", 32'(in_ready_o[1]), 32'h0);
         end
      end
      drive(1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();

      // Asynchronous reset mid-transfer.
      drive(0, 1'b1, 32'h0000_0300, 32'h0000_0033, 1'b0, 1'b0);
      drive(1, 1'b1, 32'h0000_0400, 32'h0000_0044, 1'b0, 1'b0);
      tick();
      tick();
      #2;
      Reset = 1'b0;
      #1;
      check("arst_u0_valid", 32'(out_valid_o[0]), 32'h0);
      check("arst_u0_pc", pc_o[0], 32'h0);
      check("arst_u0_instr", instr_o[0], 32'h0);
      check("arst_u0_bubbles", bc_o[0], 32'h0);
      check("arst_u0_ready", 32'(in_ready_o[0]), 32'h1);
      check("arst_u1_valid", 32'(out_valid_o[1]), 32'h0);
      check("arst_u1_instr", instr_o[1], 32'h0);
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge Clk);
      #1;
      Reset = 1'b1;

      // Ten empty cycles: 3-bit counter pins at 7, 16-bit one reaches 10.
      repeat (10) tick();
      check("sat_bubbles_3b", bc_o[2], 32'd7);
      check("sat_bubbles_16b", bc_o[0], 32'd10);

      @(negedge Clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
